// File: rtl/axi4lite_slave_regs.sv
// axi4lite_slave_regs: AXI4-Lite register bank with one-entry AW/W holding buffers.
// Optional macro AXI4LITE_SLAVE_WSTRB_EN enables byte-lane write strobes.
module axi4lite_slave_regs #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NREGS      = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [ADDR_WIDTH-1:0]  AWADDR,
    input  logic [2:0]             AWPROT,
    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic [WIDTH-1:0]       WDATA,
    input  logic [WIDTH/8-1:0]     WSTRB,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [1:0]             BRESP,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    input  logic [ADDR_WIDTH-1:0]  ARADDR,
    input  logic [2:0]             ARPROT,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [WIDTH-1:0]       RDATA,
    output logic [1:0]             RRESP,
    output logic [NREGS*WIDTH-1:0] regs_out
);

    localparam int IDXW   = $clog2(NREGS);
    localparam int NBYTES = WIDTH / 8;

    logic             aw_full;
    logic [IDXW-1:0]  aw_idx;
    logic             aw_oor;
    logic             w_full;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] regs [NREGS];

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             r_done;
    logic             commit;
    logic [IDXW-1:0]  ar_idx;
    logic             ar_oor;

    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign r_done = RVALID & RREADY;
    assign commit = aw_full & w_full & (~BVALID | BREADY);
    assign ar_idx = ARADDR[IDXW+1:2];
    assign ar_oor = |ARADDR[ADDR_WIDTH-1:IDXW+2];

`ifdef AXI4LITE_SLAVE_WSTRB_EN
    logic [NBYTES-1:0] w_strb;
    logic              unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
`else
    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0], WSTRB};
`endif

    // AW holding buffer: keeps decoded index/range, AWREADY mirrors "empty"
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full <= 1'b0;
            AWREADY <= 1'b0;
            aw_idx  <= '0;
            aw_oor  <= 1'b0;
        end else if (commit) begin
            aw_full <= 1'b0;
            AWREADY <= 1'b1;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            AWREADY <= 1'b0;
            aw_idx  <= AWADDR[IDXW+1:2];
            aw_oor  <= |AWADDR[ADDR_WIDTH-1:IDXW+2];
        end else begin
            AWREADY <= ~aw_full;
        end
    end

    // W holding buffer: independent of AW so either may arrive first
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_full <= 1'b0;
            WREADY <= 1'b0;
            w_data <= '0;
`ifdef AXI4LITE_SLAVE_WSTRB_EN
            w_strb <= '0;
`endif
        end else if (commit) begin
            w_full <= 1'b0;
            WREADY <= 1'b1;
        end else if (w_hs) begin
            w_full <= 1'b1;
            WREADY <= 1'b0;
            w_data <= WDATA;
`ifdef AXI4LITE_SLAVE_WSTRB_EN
            w_strb <= WSTRB;
`endif
        end else begin
            WREADY <= ~w_full;
        end
    end

    // Write response: a commit overrides a concurrent B handshake
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            BVALID <= 1'b0;
            BRESP  <= 2'b00;
        end else if (commit) begin
            BVALID <= 1'b1;
            BRESP  <= aw_oor ? 2'b10 : 2'b00;
        end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
        end
    end

    // Register array update on an in-range commit
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && !aw_oor) begin
`ifdef AXI4LITE_SLAVE_WSTRB_EN
            for (int k = 0; k < NBYTES; k++) begin
                if (w_strb[k]) begin
                    regs[aw_idx][k*8 +: 8] <= w_data[k*8 +: 8];
                end
            end
`else
            regs[aw_idx] <= w_data;
`endif
        end
    end

    // Read channel: one outstanding read; data sampled pre-write
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
        end else if (ar_hs) begin
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            RDATA   <= ar_oor ? '0 : regs[ar_idx];
            RRESP   <= ar_oor ? 2'b10 : 2'b00;
        end else if (r_done) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
        end else begin
            ARREADY <= ~RVALID;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_out
        assign regs_out[i*WIDTH +: WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// tb_axi4lite_slave_regs: randomized self-checking bench for axi4lite_slave_regs.
// Reference model is a plain word array updated from the bank's access rules.
module tb_axi4lite_slave_regs;

    localparam int W  = 32;
    localparam int AW = 32;
    localparam int N  = 8;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic [W-1:0]  WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic [N*W-1:0] regs_out;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [N];

    axi4lite_slave_regs #(.WIDTH(W), .ADDR_WIDTH(AW), .NREGS(N)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .regs_out(regs_out)
    );

    always #5 ACLK = ~ACLK;

    function automatic void mdl_reset();
        for (int i = 0; i < N; i++) mdl[i] = '0;
    endfunction

    function automatic logic [1:0] mdl_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
        if (a >= N * 4) return 2'b10;
`ifdef AXI4LITE_SLAVE_WSTRB_EN
        for (int k = 0; k < 4; k++)
            if (s[k]) mdl[a / 4][k*8 +: 8] = d[k*8 +: 8];
`else
        mdl[a / 4] = d;
`endif
        return 2'b00;
    endfunction

    function automatic logic [N*W-1:0] mdl_flat();
        logic [N*W-1:0] f;
        for (int i = 0; i < N; i++) f[i*W +: W] = mdl[i];
        return f;
    endfunction

    // Full write transaction, entered and left at a falling edge.
    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awdly, input int wdly, input int bdly,
                             output logic [1:0] resp, output bit ok);
        bit aw_go, w_go, b_go;
        ok = 0;
        resp = 2'bxx;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 0; WVALID = 0; BREADY = 0;
        for (int n = 0; n < 40; n++) begin
            if (n == awdly) AWVALID = 1;
            if (n == wdly) WVALID = 1;
            if (n == bdly) BREADY = 1;
            aw_go = AWVALID && AWREADY;
            w_go = WVALID && WREADY;
            b_go = BVALID && BREADY;
            if (b_go) resp = BRESP;
            @(negedge ACLK);
            if (aw_go) AWVALID = 0;
            if (w_go) WVALID = 0;
            if (b_go) begin
                ok = 1;
                break;
            end
        end
        AWVALID = 0; WVALID = 0; BREADY = 0;
    endtask

    task automatic read_txn(input logic [31:0] a, input int rdly,
                            output logic [31:0] data, output logic [1:0] resp, output bit ok);
        bit ar_go, r_go;
        ok = 0;
        data = 'x;
        resp = 2'bxx;
        ARADDR = a; ARVALID = 1; RREADY = 0;
        for (int n = 0; n < 40; n++) begin
            if (n == rdly) RREADY = 1;
            ar_go = ARVALID && ARREADY;
            r_go = RVALID && RREADY;
            if (r_go) begin
                data = RDATA;
                resp = RRESP;
            end
            @(negedge ACLK);
            if (ar_go) ARVALID = 0;
            if (r_go) begin
                ok = 1;
                break;
            end
        end
        ARVALID = 0; RREADY = 0;
    endtask

    task automatic test_reset();
        ARESETn = 0;
        repeat (3) @(negedge ACLK);
        tests++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            fails++;
            $display("FAIL reset_hs: got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        tests++;
        if ({BRESP, RRESP, RDATA} !== '0 || regs_out !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h/%h/%h regs %h want 0", BRESP, RRESP, RDATA, regs_out);
        end
        ARESETn = 1;
        #1;
        tests++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            fails++;
            $display("FAIL reset_release: got %b want 000", {AWREADY, WREADY, ARREADY});
        end
        @(negedge ACLK);
        tests++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            fails++;
            $display("FAIL reset_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
        end
        mdl_reset();
    endtask

    task automatic test_same_cycle();
        logic [1:0] r;
        AWADDR = 32'h4; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        AWVALID = 1; WVALID = 1; BREADY = 0;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        tests++;
        if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
            fails++;
            $display("FAIL same_hs: got %b want 000", {AWREADY, WREADY, BVALID});
        end
        @(negedge ACLK);
        r = mdl_write(32'h4, 32'hDEADBEEF, 4'hF);
        tests++;
        if ({AWREADY, WREADY, BVALID} !== 3'b111 || BRESP !== r) begin
            fails++;
            $display("FAIL same_commit: got %b resp %b want 111 resp %b",
                     {AWREADY, WREADY, BVALID}, BRESP, r);
        end
        tests++;
        if (regs_out[32 +: 32] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL same_word1: got %h want deadbeef", regs_out[32 +: 32]);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
        tests++;
        if (BVALID !== 1'b0) begin
            fails++;
            $display("FAIL same_bclear: got %b want 0", BVALID);
        end
        ARADDR = 32'h4; ARVALID = 1; RREADY = 0;
        @(negedge ACLK);
        ARVALID = 0;
        tests++;
        if ({RVALID, ARREADY} !== 2'b10 || RDATA !== mdl[1] || RRESP !== 2'b00) begin
            fails++;
            $display("FAIL same_read: got v/r %b data %h resp %b want 10 %h 00",
                     {RVALID, ARREADY}, RDATA, RRESP, mdl[1]);
        end
        RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
        tests++;
        if ({RVALID, ARREADY} !== 2'b01) begin
            fails++;
            $display("FAIL same_rclear: got %b want 01", {RVALID, ARREADY});
        end
    endtask

    task automatic test_w_first();
        logic [1:0] r;
        WDATA = 32'h11111111; WSTRB = 4'hF; WVALID = 1;
        @(negedge ACLK);
        WVALID = 0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({WREADY, BVALID} !== 2'b00) begin
                fails++;
                $display("FAIL wfirst_hold: got %b want 00", {WREADY, BVALID});
            end
            @(negedge ACLK);
        end
        AWADDR = 32'h8; AWVALID = 1;
        @(negedge ACLK);
        AWVALID = 0;
        tests++;
        if (BVALID !== 1'b0) begin
            fails++;
            $display("FAIL wfirst_early: got %b want 0", BVALID);
        end
        @(negedge ACLK);
        r = mdl_write(32'h8, 32'h11111111, 4'hF);
        tests++;
        if (BVALID !== 1'b1 || BRESP !== r || regs_out !== mdl_flat()) begin
            fails++;
            $display("FAIL wfirst_commit: got b %b resp %b word2 %h want 1 %b %h",
                     BVALID, BRESP, regs_out[64 +: 32], r, mdl[2]);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
    endtask

    task automatic test_out_of_range();
        logic [1:0] r, er;
        logic [31:0] d, a;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 32'h40 : ($urandom | 32'h100);
            er = mdl_write(a, 32'h12345678, 4'hF);
            write_txn(a, 32'h12345678, 4'hF, 0, 0, 0, r, ok);
            tests++;
            if (!ok || r !== er || er !== 2'b10 || regs_out !== mdl_flat()) begin
                fails++;
                $display("FAIL oor_write: ok %0d addr %h resp %b want 10 regs %h want %h",
                         ok, a, r, regs_out, mdl_flat());
            end
            read_txn(a, 0, d, r, ok);
            tests++;
            if (!ok || d !== 32'h0 || r !== 2'b10) begin
                fails++;
                $display("FAIL oor_read: ok %0d addr %h data %h resp %b want 0 10", ok, a, d, r);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        logic [1:0] r1, r2;
        d1 = $urandom; d2 = $urandom;
        AWADDR = 32'h14; WDATA = d1; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        @(negedge ACLK);
        r1 = mdl_write(32'h14, d1, 4'hF);
        AWADDR = 32'h18; WDATA = d2; AWVALID = 1; WVALID = 1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (BVALID !== 1'b1 || BRESP !== r1 || regs_out !== mdl_flat()) begin
                fails++;
                $display("FAIL b2b_hold: b %b resp %b want 1 %b regs %h want %h",
                         BVALID, BRESP, r1, regs_out, mdl_flat());
            end
            @(negedge ACLK);
            AWVALID = 0; WVALID = 0;
        end
        tests++;
        if ({AWREADY, WREADY} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_buffered: got %b want 00", {AWREADY, WREADY});
        end
        BREADY = 1;
        @(negedge ACLK);
        r2 = mdl_write(32'h18, d2, 4'hF);
        tests++;
        if (BVALID !== 1'b1 || BRESP !== r2 || regs_out !== mdl_flat()) begin
            fails++;
            $display("FAIL b2b_second: b %b resp %b want 1 %b word6 %h want %h",
                     BVALID, BRESP, r2, regs_out[192 +: 32], mdl[6]);
        end
        @(negedge ACLK);
        BREADY = 0;
        tests++;
        if (BVALID !== 1'b0) begin
            fails++;
            $display("FAIL b2b_clear: got %b want 0", BVALID);
        end
    endtask

    task automatic test_wstrb();
        logic [1:0] r;
        logic [31:0] exp;
        bit ok;
        void'(mdl_write(32'h0, 32'hAABBCCDD, 4'hF));
        write_txn(32'h0, 32'hAABBCCDD, 4'hF, 0, 0, 0, r, ok);
        void'(mdl_write(32'h0, 32'h11223344, 4'b0101));
        write_txn(32'h0, 32'h11223344, 4'b0101, 1, 0, 2, r, ok);
`ifdef AXI4LITE_SLAVE_WSTRB_EN
        exp = 32'hAA22CC44;
`else
        exp = 32'h11223344;
`endif
        tests++;
        if (!ok || r !== 2'b00 || regs_out[31:0] !== exp) begin
            fails++;
            $display("FAIL wstrb_0101: ok %0d resp %b word0 %h want %h", ok, r, regs_out[31:0], exp);
        end
        void'(mdl_write(32'h0, 32'h55667788, 4'b0000));
        write_txn(32'h0, 32'h55667788, 4'b0000, 0, 1, 0, r, ok);
        tests++;
        if (!ok || r !== 2'b00 || regs_out !== mdl_flat()) begin
            fails++;
            $display("FAIL wstrb_zero: ok %0d resp %b word0 %h want %h", ok, r, regs_out[31:0], mdl[0]);
        end
    endtask

    task automatic test_read_write_same_edge();
        logic [31:0] old, nw;
        old = mdl[3];
        nw = ~old;
        AWADDR = 32'hC; WDATA = nw; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        ARADDR = 32'hC; ARVALID = 1; RREADY = 0;
        @(negedge ACLK);
        ARVALID = 0;
        void'(mdl_write(32'hC, nw, 4'hF));
        tests++;
        if (RVALID !== 1'b1 || RDATA !== old || BVALID !== 1'b1 || regs_out !== mdl_flat()) begin
            fails++;
            $display("FAIL rw_same: rv %b data %h want %h bv %b word3 %h want %h",
                     RVALID, RDATA, old, BVALID, regs_out[96 +: 32], nw);
        end
        BREADY = 1; RREADY = 1;
        @(negedge ACLK);
        BREADY = 0; RREADY = 0;
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd;
        logic [3:0] s;
        logic [1:0] r, er;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 4) == 0) ? (32'h20 + $urandom_range(0, 255)) : $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                er = mdl_write(a, d, s);
                write_txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r, ok);
                tests++;
                if (!ok || r !== er || regs_out !== mdl_flat()) begin
                    fails++;
                    $display("FAIL rand_write: ok %0d addr %h resp %b want %b regs %h want %h",
                             ok, a, r, er, regs_out, mdl_flat());
                end
            end else begin
                read_txn(a, $urandom_range(0, 3), rd, r, ok);
                tests++;
                if (!ok || rd !== ((a >= N * 4) ? 32'h0 : mdl[a / 4]) || r !== ((a >= N * 4) ? 2'b10 : 2'b00)) begin
                    fails++;
                    $display("FAIL rand_read: ok %0d addr %h data %h resp %b", ok, a, rd, r);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ARADDR = 32'h8; ARVALID = 1; RREADY = 0;
        @(negedge ACLK);
        ARVALID = 0;
        AWADDR = 32'h4; AWVALID = 1;
        @(negedge ACLK);
        AWVALID = 0;
        tests++;
        if ({RVALID, AWREADY} !== 2'b10) begin
            fails++;
            $display("FAIL mid_setup: got %b want 10", {RVALID, AWREADY});
        end
        #2 ARESETn = 0;
        #1;
        tests++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || regs_out !== '0) begin
            fails++;
            $display("FAIL mid_async: got %b regs %h want 00000 0",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID}, regs_out);
        end
        @(negedge ACLK);
        ARESETn = 1;
        mdl_reset();
        @(negedge ACLK);
        tests++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
            fails++;
            $display("FAIL mid_release: got %b want 11100", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1;
        @(negedge ACLK);
        WVALID = 0;
        repeat (3) begin
            tests++;
            if (BVALID !== 1'b0 || RVALID !== 1'b0 || regs_out !== mdl_flat()) begin
                fails++;
                $display("FAIL mid_stale: b %b r %b regs %h want 0 0 %h", BVALID, RVALID, regs_out, mdl_flat());
            end
            @(negedge ACLK);
        end
        AWADDR = 32'h0; AWVALID = 1;
        @(negedge ACLK);
        AWVALID = 0;
        @(negedge ACLK);
        void'(mdl_write(32'h0, 32'hCAFEF00D, 4'hF));
        tests++;
        if (BVALID !== 1'b1 || regs_out !== mdl_flat()) begin
            fails++;
            $display("FAIL mid_resume: b %b word0 %h want 1 %h", BVALID, regs_out[31:0], mdl[0]);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
    endtask

    initial begin
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        AWADDR = '0; ARADDR = '0; WDATA = '0; WSTRB = '0;
        AWPROT = 3'b010; ARPROT = 3'b101;
        mdl_reset();
        @(negedge ACLK);
        test_reset();
        test_same_cycle();
        test_w_first();
        test_out_of_range();
        test_back_to_back();
        test_wstrb();
        test_read_write_same_edge();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
